// File: rtl/rom_region_loader.sv
// rom_region_loader: splits the MiSTer ioctl download stream for one ROM index
// into NUM_REGIONS equal regions of 2^REGION_AW bytes and drives per-region
// ROM write strobes. Each strobe is held for WR_STRETCH cycles while
// ioctl_wait holds off the HPS. The block also tracks load status.
//
// Ports:
//   CLK, RESET         system clock, synchronous active-high reset
//   ioctl_download     download window active
//   ioctl_index        ROM index of the current download
//   ioctl_wr           single-cycle byte strobe
//   ioctl_addr         byte address
//   ioctl_dout         byte data
//   ioctl_wait         hold-off to the HPS (high while a write is in flight)
//   rom_addr           address within the selected region
//   rom_data           byte to write
//   rom_cs             one-hot region select, valid while rom_wr=1
//   rom_wr             write strobe
//   loaded             sticky per-region "received a byte" mask
//   byte_count         accepted in-range bytes, saturating
//   checksum           mod-256 sum of accepted bytes
//   err_range          sticky: a byte fell outside all regions
//   err_overrun        sticky: ioctl_wr arrived while busy
//   done               download for DL_INDEX completed
module rom_region_loader #(
    parameter int unsigned NUM_REGIONS = 15,
    parameter int unsigned REGION_AW   = 12,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned DL_INDEX    = 0,
    parameter int unsigned WR_STRETCH  = 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   ioctl_download,
    input  logic [7:0]             ioctl_index,
    input  logic                   ioctl_wr,
    input  logic [24:0]            ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    output logic                   ioctl_wait,
    output logic [REGION_AW-1:0]   rom_addr,
    output logic [7:0]             rom_data,
    output logic [NUM_REGIONS-1:0] rom_cs,
    output logic                   rom_wr,
    output logic [NUM_REGIONS-1:0] loaded,
    output logic [24:0]            byte_count,
    output logic [7:0]             checksum,
    output logic                   err_range,
    output logic                   err_overrun,
    output logic                   done
);

    localparam int unsigned AW = 25;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                 state;
    logic                   prev_download;
    logic [CW-1:0]          hold_cnt;

    logic [AW-1:0]          off;
    logic [AW-1:0]          region;
    logic                   in_range;
    logic                   busy;
    logic                   start;
    logic [NUM_REGIONS-1:0] cs_onehot;

    // Address decode of the incoming byte; wrap-around of off below BASE_ADDR
    // is rejected by the explicit lower-bound compare.
    assign off       = ioctl_addr - AW'(BASE_ADDR);
    assign region    = off >> REGION_AW;
    assign in_range  = (ioctl_addr >= AW'(BASE_ADDR)) && (region < AW'(NUM_REGIONS));
    assign cs_onehot = NUM_REGIONS'(1) << region;

    // A write is in flight while the stretch counter is nonzero.
    assign busy  = (hold_cnt != CW'(0));

    // Index is qualified only at the rising edge of the download window.
    assign start = ioctl_download && !prev_download && (ioctl_index == 8'(DL_INDEX));

    // Loader FSM, strobe stretcher and status registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= S_IDLE;
            prev_download <= 1'b0;
            hold_cnt      <= '0;
            ioctl_wait    <= 1'b0;
            rom_addr      <= '0;
            rom_data      <= '0;
            rom_cs        <= '0;
            rom_wr        <= 1'b0;
            loaded        <= '0;
            byte_count    <= '0;
            checksum      <= '0;
            err_range     <= 1'b0;
            err_overrun   <= 1'b0;
            done          <= 1'b0;
        end else begin
            prev_download <= ioctl_download;

            // Count down the current strobe; drop it after its last cycle.
            if (busy) begin
                hold_cnt <= hold_cnt - CW'(1);
                if (hold_cnt == CW'(1)) begin
                    rom_wr     <= 1'b0;
                    ioctl_wait <= 1'b0;
                    rom_cs     <= '0;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_LOAD;
                        loaded      <= '0;
                        byte_count  <= '0;
                        checksum    <= '0;
                        err_range   <= 1'b0;
                        err_overrun <= 1'b0;
                        done        <= 1'b0;
                    end
                end

                S_LOAD: begin
                    // A strobe coinciding with the falling window is still taken.
                    if (ioctl_wr) begin
                        if (busy) begin
                            err_overrun <= 1'b1;
                        end else if (in_range) begin
                            rom_addr   <= off[REGION_AW-1:0];
                            rom_data   <= ioctl_dout;
                            rom_cs     <= cs_onehot;
                            rom_wr     <= 1'b1;
                            ioctl_wait <= 1'b1;
                            hold_cnt   <= CW'(WR_STRETCH);
                            loaded     <= loaded | cs_onehot;
                            checksum   <= checksum + ioctl_dout;
                            if (byte_count != '1) begin
                                byte_count <= byte_count + AW'(1);
                            end
                        end else begin
                            err_range <= 1'b1;
                        end
                    end
                    if (!ioctl_download) begin
                        state <= S_FLUSH;
                    end
                end

                S_FLUSH: begin
                    if (!busy) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_region_loader.sv
// Testbench for rom_region_loader: a default instance (u0, WR_STRETCH=1) and a
// stretched instance (u4, WR_STRETCH=4) share one stimulus stream; directed
// steps check each against hand-computed values.
module tb_rom_region_loader;

    logic        clk;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic        wait0, wr0, err_r0, err_o0, done0;
    logic [11:0] addr0;
    logic [7:0]  data0, sum0;
    logic [14:0] cs0, loaded0;
    logic [24:0] cnt0;

    logic        wait4, wr4, err_r4, err_o4, done4;
    logic [11:0] addr4;
    logic [7:0]  data4, sum4;
    logic [14:0] cs4, loaded4;
    logic [24:0] cnt4;

    int total = 0;
    int bad   = 0;

    rom_region_loader u0 (
        .CLK(clk), .RESET(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(wait0), .rom_addr(addr0), .rom_data(data0), .rom_cs(cs0),
        .rom_wr(wr0), .loaded(loaded0), .byte_count(cnt0), .checksum(sum0),
        .err_range(err_r0), .err_overrun(err_o0), .done(done0)
    );

    rom_region_loader #(.WR_STRETCH(4)) u4 (
        .CLK(clk), .RESET(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(wait4), .rom_addr(addr4), .rom_data(data4), .rom_cs(cs4),
        .rom_wr(wr4), .loaded(loaded4), .byte_count(cnt4), .checksum(sum4),
        .err_range(err_r4), .err_overrun(err_o4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Present one byte strobe for a single cycle.
    task automatic put_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        step();
        ioctl_wr   = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        idle_steps(2);
        reset = 1'b0;

        // Reset state
        chk("rst_wr0", 32'(wr0), 0);
        chk("rst_wait0", 32'(wait0), 0);
        chk("rst_cs0", 32'(cs0), 0);
        chk("rst_loaded0", 32'(loaded0), 0);
        chk("rst_cnt0", 32'(cnt0), 0);
        chk("rst_done0", 32'(done0), 0);
        chk("rst_wr4", 32'(wr4), 0);

        // Matching download with three in-range bytes
        ioctl_download = 1'b1;
        step();
        put_byte(25'h0000, 8'h11);
        chk("b1_wr0", 32'(wr0), 1);
        chk("b1_wait0", 32'(wait0), 1);
        chk("b1_cs0", 32'(cs0), 32'h0001);
        chk("b1_addr0", 32'(addr0), 32'h000);
        chk("b1_data0", 32'(data0), 32'h11);
        step();
        chk("b1_wr0_off", 32'(wr0), 0);
        chk("b1_cs0_off", 32'(cs0), 0);
        chk("b1_wr4_held", 32'(wr4), 1);
        idle_steps(3);
        chk("b1_wr4_off", 32'(wr4), 0);

        put_byte(25'h1FFF, 8'h22);
        chk("b2_cs0", 32'(cs0), 32'h0002);
        chk("b2_addr0", 32'(addr0), 32'hFFF);
        idle_steps(4);

        put_byte(25'hE000, 8'h33);
        chk("b3_cs0", 32'(cs0), 32'h4000);
        chk("b3_addr0", 32'(addr0), 32'h000);
        idle_steps(4);
        chk("ld_loaded0", 32'(loaded0), 32'h4003);
        chk("ld_cnt0", 32'(cnt0), 3);
        chk("ld_sum0", 32'(sum0), 32'h66);
        chk("ld_sum4", 32'(sum4), 32'h66);

        // Out-of-range byte
        put_byte(25'hF000, 8'h44);
        chk("oor_wr0", 32'(wr0), 0);
        chk("oor_err0", 32'(err_r0), 1);
        chk("oor_cnt0", 32'(cnt0), 3);

        // Close download: FLUSH then DONE
        ioctl_download = 1'b0;
        step();
        chk("flush_done0", 32'(done0), 0);
        step();
        chk("done0", 32'(done0), 1);
        chk("done4", 32'(done4), 1);

        // Non-matching download is ignored
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        step();
        put_byte(25'h0000, 8'h55);
        chk("nm_wr0", 32'(wr0), 0);
        chk("nm_done0", 32'(done0), 1);
        chk("nm_cnt0", 32'(cnt0), 3);
        chk("nm_loaded0", 32'(loaded0), 32'h4003);
        chk("nm_err0", 32'(err_r0), 1);
        ioctl_download = 1'b0;
        step();
        ioctl_index = 8'd0;

        // Second matching download restarts status
        ioctl_download = 1'b1;
        step();
        chk("re_done0", 32'(done0), 0);
        chk("re_cnt0", 32'(cnt0), 0);
        chk("re_loaded0", 32'(loaded0), 0);
        chk("re_sum0", 32'(sum0), 0);
        chk("re_err0", 32'(err_r0), 0);

        // Stretched write plus an overrunning byte one cycle later
        put_byte(25'h3010, 8'h05);
        chk("st_cs4", 32'(cs4), 32'h0008);
        chk("st_addr4", 32'(addr4), 32'h010);
        chk("st_wr4_c1", 32'(wr4), 1);
        chk("st_wait4_c1", 32'(wait4), 1);
        put_byte(25'h3011, 8'h07);
        chk("st_wr4_c2", 32'(wr4), 1);
        chk("st_ovr4", 32'(err_o4), 1);
        chk("st_ovr0", 32'(err_o0), 1);
        chk("st_wr0", 32'(wr0), 0);
        step();
        chk("st_wr4_c3", 32'(wr4), 1);
        step();
        chk("st_wr4_c4", 32'(wr4), 1);
        chk("st_wait4_c4", 32'(wait4), 1);
        chk("st_data4", 32'(data4), 32'h05);
        step();
        chk("st_wr4_c5", 32'(wr4), 0);
        chk("st_wait4_c5", 32'(wait4), 0);
        chk("st_cs4_off", 32'(cs4), 0);
        chk("st_cnt4", 32'(cnt4), 1);
        chk("st_sum4", 32'(sum4), 32'h05);
        chk("st_cnt0", 32'(cnt0), 1);

        // Reset in cycle 2 of a stretched write
        put_byte(25'h0001, 8'h09);
        chk("rw_wr4_c1", 32'(wr4), 1);
        step();
        chk("rw_wr4_c2", 32'(wr4), 1);
        reset          = 1'b1;
        ioctl_download = 1'b0;
        step();
        chk("rw_wr4", 32'(wr4), 0);
        chk("rw_wait4", 32'(wait4), 0);
        chk("rw_cs4", 32'(cs4), 0);
        chk("rw_addr4", 32'(addr4), 0);
        chk("rw_data4", 32'(data4), 0);
        chk("rw_loaded4", 32'(loaded4), 0);
        chk("rw_cnt4", 32'(cnt4), 0);
        chk("rw_sum4", 32'(sum4), 0);
        chk("rw_ovr4", 32'(err_o4), 0);
        chk("rw_done4", 32'(done4), 0);
        reset = 1'b0;
        step();

        // Normal load after reset
        ioctl_download = 1'b1;
        step();
        put_byte(25'h2005, 8'hAA);
        chk("pr_cs4", 32'(cs4), 32'h0004);
        chk("pr_addr4", 32'(addr4), 32'h005);
        chk("pr_data4", 32'(data4), 32'hAA);
        idle_steps(4);
        ioctl_download = 1'b0;
        step();
        step();
        chk("pr_done4", 32'(done4), 1);
        chk("pr_cnt4", 32'(cnt4), 1);
        chk("pr_sum4", 32'(sum4), 32'hAA);
        chk("pr_loaded4", 32'(loaded4), 32'h0004);
        chk("pr_done0", 32'(done0), 1);
        chk("pr_loaded0", 32'(loaded0), 32'h0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_region_loader.md
Name: rom_region_loader

Overview:
- Parametrised successor to the fixed 15-region ioctl ROM selector.
- Takes the MiSTer ioctl download stream for one ROM index and splits it into NUM_REGIONS equal regions of 2^REGION_AW bytes each.
- Issues registered, optionally stretched write strobes to the per-region dual-port ROMs, and back-pressures the HPS with ioctl_wait while a write is in flight.
- Tracks load status: per-region loaded mask, byte count, 8-bit checksum, error flags and a done flag. Sits between hps_io and the eprom instances.

Parameters:
- NUM_REGIONS, 15, number of equal-size regions; one chip-select per region.
- REGION_AW, 12, address width of one region; region size is 2^REGION_AW bytes.
- BASE_ADDR, 0, ioctl address of region 0 byte 0.
- DL_INDEX, 0, ioctl_index value this loader responds to.
- WR_STRETCH, 1, cycles rom_wr is held high per byte; range 1..15.

Ports:
- CLK  in  1  system clock; also the download clock.
- RESET  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download window active.
- ioctl_index  in  8  ROM index of the current download.
- ioctl_wr  in  1  single-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  hold-off to the HPS.
- rom_addr  out  REGION_AW  address within the selected region.
- rom_data  out  8  byte to write.
- rom_cs  out  NUM_REGIONS  one-hot region select, valid while rom_wr=1.
- rom_wr  out  1  write strobe.
- loaded  out  NUM_REGIONS  sticky: region received at least one byte.
- byte_count  out  25  accepted in-range bytes, saturating at all-ones.
- checksum  out  8  mod-256 sum of accepted bytes.
- err_range  out  1  sticky: a byte fell outside all regions.
- err_overrun  out  1  sticky: ioctl_wr arrived while busy.
- done  out  1  download for DL_INDEX completed.

Behaviour:
- Reset: every output is 0; state is IDLE; any in-flight write is abandoned with rom_wr dropped the next cycle.
- Index match: "match" means ioctl_index == DL_INDEX. Downloads with any other index are fully ignored: no state change, no strobes, no status changes.
- IDLE -> LOAD: on ioctl_download=1 with match, when the previous cycle had ioctl_download=0. On this transition, clear loaded, byte_count, checksum, err_range, err_overrun and done.
- LOAD, ioctl_wr=1 while not busy:
  - Compute off = ioctl_addr - BASE_ADDR as 25-bit unsigned, and region = off >> REGION_AW.
  - In range means ioctl_addr >= BASE_ADDR and region < NUM_REGIONS.
  - In range: next cycle (latency 1), rom_addr = off[REGION_AW-1:0], rom_data = ioctl_dout, rom_cs = one-hot(region), rom_wr = 1. All of these are held for exactly WR_STRETCH cycles, then rom_wr and rom_cs return to 0. loaded[region] is set, byte_count increments (saturating), checksum += ioctl_dout.
  - Out of range: no strobe and no counting; err_range is set; not busy.
- Busy / wait: busy is 1 from the cycle after an accepted write through its last rom_wr cycle. ioctl_wait = busy, registered, so it is high in the same cycles as rom_wr. With WR_STRETCH=1, ioctl_wait pulses for one cycle per byte.
- Overrun: ioctl_wr while busy drops the byte and sets err_overrun; the in-flight write is unaffected.
- LOAD -> FLUSH: on ioctl_download falling. A write strobe in that same cycle is accepted first.
- FLUSH -> DONE: once not busy (same cycle if already idle).
- DONE: done = 1, held until RESET or a new matching download start (DONE -> LOAD with the clears above).
- Mid-download changes: an ioctl_index change during LOAD is ignored; the index is sampled only at download start.
- Status outputs are registered and update the cycle after the causing event.

Test Plan:
- Defaults, matching download, bytes 0x11 @0x0000, 0x22 @0x1FFF, 0x33 @0xE000 -> rom_wr pulses 1 cycle each:
  - rom_cs = 0x0001 / rom_addr 0x000
  - rom_cs = 0x0002 / rom_addr 0xFFF
  - rom_cs = 0x4000 / rom_addr 0x000
  - Afterwards: loaded = 0x4003, byte_count = 3, checksum = 0x66; done = 1 one cycle after FLUSH.
- Byte @0xF000 with defaults -> no rom_wr, err_range = 1, byte_count unchanged.
- WR_STRETCH=4, two bytes 1 cycle apart -> first gets 4 rom_wr cycles with ioctl_wait high for 4 cycles; second dropped, err_overrun = 1; byte_count = 1.
- Download with ioctl_index=1 while DL_INDEX=0 -> zero strobes, all status unchanged, done stays at its prior value.
- RESET asserted in cycle 2 of a WR_STRETCH=4 write -> rom_wr = 0 next cycle, all outputs 0. A subsequent download then loads normally.
- Second matching download after done -> done clears on start, counters restart from 0, checksum reflects only the new bytes.
